// File: rtl/datapath_control_unit_if.sv
// Control bundle between the hardwired control unit and the
// single-bus datapath: instruction in, strobes and counter out.
interface datapath_control_unit_if #(
  parameter int OP_W  = 5,
  parameter int CNT_W = 16
);
  logic [31:0]      IR;
  logic             Stop;
  logic             Run;
  logic             Clear;
  logic             PCout;
  logic             Zlowout;
  logic             Zhighout;
  logic             MDRout;
  logic             BAout;
  logic             Cout;
  logic             MARin;
  logic             Zin;
  logic             PCin;
  logic             MDRin;
  logic             IRin;
  logic             Yin;
  logic             HIin;
  logic             LOin;
  logic             IncPC;
  logic             Read;
  logic             Write;
  logic             Gra;
  logic             Grb;
  logic             Grc;
  logic             Rin;
  logic             Rout;
  logic [OP_W-1:0]  alu_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  IR, Stop,
    output Run, Clear,
    output PCout, Zlowout, Zhighout,
    output MDRout, BAout, Cout,
    output MARin, Zin, PCin, MDRin,
    output IRin, Yin, HIin, LOin,
    output IncPC, Read, Write,
    output Gra, Grb, Grc, Rin, Rout,
    output alu_op, instr_count
  );

  modport slave (
    output IR, Stop,
    input  Run, Clear,
    input  PCout, Zlowout, Zhighout,
    input  MDRout, BAout, Cout,
    input  MARin, Zin, PCin, MDRin,
    input  IRin, Yin, HIin, LOin,
    input  IncPC, Read, Write,
    input  Gra, Grb, Grc, Rin, Rout,
    input  alu_op, instr_count
  );
endinterface

// File: rtl/datapath_control_unit.sv
// Hardwired Moore control unit for the single-bus datapath.
// Define CU_MULDIV_EN to enable the mul/div execute sequence.
module datapath_control_unit #(
  parameter int              OP_W   = 5,
  parameter int              CNT_W  = 16,
  parameter logic [OP_W-1:0] ADD_OP = 5'b00011
) (
  input logic                 Clock,
  input logic                 Reset,
  datapath_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [OP_W-1:0] op;
  logic [26:0]     unused_ir;
  logic            is_ld, is_ldi, is_st;
  logic            is_ralu, is_ialu;
  logic            is_md, is_halt, is_nop;
  logic            done;

  logic            pc_out, zlow_out, mdr_out;
  logic            ba_out, c_out;
  logic            mar_in, z_in, pc_in, mdr_in;
  logic            ir_in, y_in;
  logic            inc_pc, rd, wr;
  logic            gra, grb, grc, r_in, r_out;
  logic            run, clr;
  logic [OP_W-1:0] alu_op;
`ifdef CU_MULDIV_EN
  logic            zhigh_out, hi_in, lo_in;
`endif

  assign op        = bus.IR[31:27];
  assign unused_ir = bus.IR[26:0];

  assign is_ld   = (op == 5'b00000);
  assign is_ldi  = (op == 5'b00001);
  assign is_st   = (op == 5'b00010);
  assign is_ralu = op inside {[5'b00011:5'b01010]};
  assign is_ialu = op inside {[5'b01011:5'b01101]};
  assign is_halt = (op == 5'b11011);
`ifdef CU_MULDIV_EN
  assign is_md   = op inside {5'b01110, 5'b01111};
`else
  assign is_md   = 1'b0;
`endif
  // nop, undefined opcodes and disabled mul/div all land here
  assign is_nop  = !(is_ld | is_ldi | is_st | is_ralu |
                     is_ialu | is_md | is_halt);

  // state and retired-instruction counter registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= RST;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // next state; Stop only matters on an instruction's last step
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      RST: state_d = T0;
      T0:  state_d = T1;
      T1:  state_d = T2;
      T2:  state_d = T3;
      T3: begin
        if (is_halt)     state_d = HALT;
        else if (is_nop) done    = 1'b1;
        else             state_d = T4;
      end
      T4:  state_d = T5;
      T5: begin
        if (is_ralu | is_ialu | is_ldi) done = 1'b1;
        else                            state_d = T6;
      end
      T6: begin
        if (is_md) done    = 1'b1;
        else       state_d = T7;
      end
      T7:   done    = 1'b1;
      HALT: state_d = HALT;
      default: state_d = RST;
    endcase
    if (done) state_d = bus.Stop ? HALT : T0;
  end

  // count instructions as they leave fetch; wraps naturally
  always_comb begin
    count_d = count_q;
    if (state_q == T2) count_d = count_q + CNT_W'(1);
  end

  // Moore strobe decode from state and opcode only
  always_comb begin
    pc_out   = 1'b0;
    zlow_out = 1'b0;
    mdr_out  = 1'b0;
    ba_out   = 1'b0;
    c_out    = 1'b0;
    mar_in   = 1'b0;
    z_in     = 1'b0;
    pc_in    = 1'b0;
    mdr_in   = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    inc_pc   = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    gra      = 1'b0;
    grb      = 1'b0;
    grc      = 1'b0;
    r_in     = 1'b0;
    r_out    = 1'b0;
    run      = 1'b0;
    clr      = 1'b0;
    alu_op   = '0;
`ifdef CU_MULDIV_EN
    zhigh_out = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
`endif
    unique case (state_q)
      RST: clr = 1'b1;
      T0: begin
        run    = 1'b1;
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      T1: begin
        run      = 1'b1;
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        rd       = 1'b1;
        mdr_in   = 1'b1;
      end
      T2: begin
        run     = 1'b1;
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T3: begin
        run = 1'b1;
        if (is_ralu | is_ialu) begin
          grb   = 1'b1;
          r_out = 1'b1;
          y_in  = 1'b1;
        end else if (is_ld | is_ldi | is_st) begin
          grb    = 1'b1;
          ba_out = 1'b1;
          y_in   = 1'b1;
        end else if (is_md) begin
          gra   = 1'b1;
          r_out = 1'b1;
          y_in  = 1'b1;
        end
      end
      T4: begin
        run  = 1'b1;
        z_in = 1'b1;
        if (is_ralu) begin
          grc    = 1'b1;
          r_out  = 1'b1;
          alu_op = op;
        end else if (is_ialu) begin
          c_out  = 1'b1;
          alu_op = op;
        end else if (is_md) begin
          grb    = 1'b1;
          r_out  = 1'b1;
          alu_op = op;
        end else begin
          c_out  = 1'b1;
          alu_op = ADD_OP;
        end
      end
      T5: begin
        run      = 1'b1;
        zlow_out = 1'b1;
        if (is_ld | is_st) begin
          mar_in = 1'b1;
        end else if (is_md) begin
`ifdef CU_MULDIV_EN
          lo_in = 1'b1;
`endif
        end else begin
          gra  = 1'b1;
          r_in = 1'b1;
        end
      end
      T6: begin
        run = 1'b1;
        if (is_ld) begin
          rd     = 1'b1;
          mdr_in = 1'b1;
        end else if (is_st) begin
          gra    = 1'b1;
          r_out  = 1'b1;
          mdr_in = 1'b1;
        end else if (is_md) begin
`ifdef CU_MULDIV_EN
          zhigh_out = 1'b1;
          hi_in     = 1'b1;
`endif
        end
      end
      T7: begin
        run = 1'b1;
        if (is_ld) begin
          mdr_out = 1'b1;
          gra     = 1'b1;
          r_in    = 1'b1;
        end else begin
          wr = 1'b1;
        end
      end
      HALT: ;
      default: ;
    endcase
  end

  assign bus.Run         = run;
  assign bus.Clear       = clr;
  assign bus.PCout       = pc_out;
  assign bus.Zlowout     = zlow_out;
  assign bus.MDRout      = mdr_out;
  assign bus.BAout       = ba_out;
  assign bus.Cout        = c_out;
  assign bus.MARin       = mar_in;
  assign bus.Zin         = z_in;
  assign bus.PCin        = pc_in;
  assign bus.MDRin       = mdr_in;
  assign bus.IRin        = ir_in;
  assign bus.Yin         = y_in;
  assign bus.IncPC       = inc_pc;
  assign bus.Read        = rd;
  assign bus.Write       = wr;
  assign bus.Gra         = gra;
  assign bus.Grb         = grb;
  assign bus.Grc         = grc;
  assign bus.Rin         = r_in;
  assign bus.Rout        = r_out;
  assign bus.alu_op      = alu_op;
  assign bus.instr_count = count_q;
`ifdef CU_MULDIV_EN
  assign bus.Zhighout    = zhigh_out;
  assign bus.HIin        = hi_in;
  assign bus.LOin        = lo_in;
`else
  assign bus.Zhighout    = 1'b0;
  assign bus.HIin        = 1'b0;
  assign bus.LOin        = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_control_unit.sv
// Bench for datapath_control_unit: directed steps plus random
// instructions checked against a per-opcode strobe table.
module tb_datapath_control_unit;

  logic Clock;
  logic Reset;

  datapath_control_unit_if #(.OP_W(5), .CNT_W(8)) bus ();

  datapath_control_unit #(.CNT_W(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [23:0] M_PCOUT = 24'd1 << 23;
  localparam logic [23:0] M_ZLOW  = 24'd1 << 22;
  localparam logic [23:0] M_ZHIGH = 24'd1 << 21;
  localparam logic [23:0] M_MDRO  = 24'd1 << 20;
  localparam logic [23:0] M_BAO   = 24'd1 << 19;
  localparam logic [23:0] M_COUT  = 24'd1 << 18;
  localparam logic [23:0] M_MARI  = 24'd1 << 17;
  localparam logic [23:0] M_ZIN   = 24'd1 << 16;
  localparam logic [23:0] M_PCIN  = 24'd1 << 15;
  localparam logic [23:0] M_MDRI  = 24'd1 << 14;
  localparam logic [23:0] M_IRIN  = 24'd1 << 13;
  localparam logic [23:0] M_YIN   = 24'd1 << 12;
  localparam logic [23:0] M_HIIN  = 24'd1 << 11;
  localparam logic [23:0] M_LOIN  = 24'd1 << 10;
  localparam logic [23:0] M_INCPC = 24'd1 << 9;
  localparam logic [23:0] M_READ  = 24'd1 << 8;
  localparam logic [23:0] M_WRITE = 24'd1 << 7;
  localparam logic [23:0] M_GRA   = 24'd1 << 6;
  localparam logic [23:0] M_GRB   = 24'd1 << 5;
  localparam logic [23:0] M_GRC   = 24'd1 << 4;
  localparam logic [23:0] M_RIN   = 24'd1 << 3;
  localparam logic [23:0] M_ROUT  = 24'd1 << 2;
  localparam logic [23:0] M_CLEAR = 24'd1 << 1;
  localparam logic [23:0] M_RUN   = 24'd1 << 0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mcnt;
  logic [23:0] exp_m [8];
  logic [4:0]  exp_a [8];
  int          exp_n;
  bit          exp_halt;
  bit          halted;

  function automatic logic [23:0] obs();
    return {bus.PCout, bus.Zlowout, bus.Zhighout,
            bus.MDRout, bus.BAout, bus.Cout,
            bus.MARin, bus.Zin, bus.PCin, bus.MDRin,
            bus.IRin, bus.Yin, bus.HIin, bus.LOin,
            bus.IncPC, bus.Read, bus.Write,
            bus.Gra, bus.Grb, bus.Grc,
            bus.Rin, bus.Rout, bus.Clear, bus.Run};
  endfunction

  task automatic chk(input string tag,
                     input logic [23:0] em,
                     input logic [4:0] ea);
    logic [23:0] om;
    om = obs();
    n_cmp++;
    assert (om === em) else begin
      n_bad++;
      $error("FAIL %s strobes obs=%h exp=%h", tag, om, em);
    end
    n_cmp++;
    assert (bus.alu_op === ea) else begin
      n_bad++;
      $error("FAIL %s alu_op obs=%b exp=%b",
             tag, bus.alu_op, ea);
    end
    n_cmp++;
    assert (bus.instr_count === mcnt) else begin
      n_bad++;
      $error("FAIL %s count obs=%h exp=%h",
             tag, bus.instr_count, mcnt);
    end
  endtask

  // Per-opcode cycle table: fetch, then the opcode's execute steps
  task automatic build(input logic [4:0] op);
    bit md_on;
`ifdef CU_MULDIV_EN
    md_on = 1'b1;
`else
    md_on = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      exp_m[i] = M_RUN;
      exp_a[i] = 5'd0;
    end
    exp_halt = 1'b0;
    exp_m[0] |= M_PCOUT | M_MARI | M_INCPC | M_ZIN;
    exp_m[1] |= M_ZLOW | M_PCIN | M_READ | M_MDRI;
    exp_m[2] |= M_MDRO | M_IRIN;
    if (op >= 3 && op <= 10) begin
      exp_m[3] |= M_GRB | M_ROUT | M_YIN;
      exp_m[4] |= M_GRC | M_ROUT | M_ZIN;
      exp_a[4]  = op;
      exp_m[5] |= M_ZLOW | M_GRA | M_RIN;
      exp_n = 6;
    end else if (op >= 11 && op <= 13) begin
      exp_m[3] |= M_GRB | M_ROUT | M_YIN;
      exp_m[4] |= M_COUT | M_ZIN;
      exp_a[4]  = op;
      exp_m[5] |= M_ZLOW | M_GRA | M_RIN;
      exp_n = 6;
    end else if (op <= 2) begin
      exp_m[3] |= M_GRB | M_BAO | M_YIN;
      exp_m[4] |= M_COUT | M_ZIN;
      exp_a[4]  = 5'b00011;
      if (op == 1) begin
        exp_m[5] |= M_ZLOW | M_GRA | M_RIN;
        exp_n = 6;
      end else begin
        exp_m[5] |= M_ZLOW | M_MARI;
        if (op == 0) begin
          exp_m[6] |= M_READ | M_MDRI;
          exp_m[7] |= M_MDRO | M_GRA | M_RIN;
        end else begin
          exp_m[6] |= M_GRA | M_ROUT | M_MDRI;
          exp_m[7] |= M_WRITE;
        end
        exp_n = 8;
      end
    end else if ((op == 14 || op == 15) && md_on) begin
      exp_m[3] |= M_GRA | M_ROUT | M_YIN;
      exp_m[4] |= M_GRB | M_ROUT | M_ZIN;
      exp_a[4]  = op;
      exp_m[5] |= M_ZLOW | M_LOIN;
      exp_m[6] |= M_ZHIGH | M_HIIN;
      exp_n = 7;
    end else begin
      exp_n    = 4;
      exp_halt = (op == 5'b11011);
    end
  endtask

  // Entered with the DUT in T0; smode 0=Stop low,
  // 1=Stop high from T3, 2=random Stop every cycle
  task automatic run_instr(input logic [31:0] ir,
                           input int smode,
                           input int abort_at);
    logic  s_last;
    string tag;
    halted  = 1'b0;
    s_last  = 1'b0;
    bus.IR  = ir;
    build(ir[31:27]);
    for (int i = 0; i < exp_n; i++) begin
      if (i == 3) mcnt = mcnt + 8'd1;
      tag = $sformatf("op%b_s%0d", ir[31:27], i);
      chk(tag, exp_m[i], exp_a[i]);
      if (i == abort_at) begin
        Reset = 1'b1;
        #2;
        mcnt = 8'd0;
        chk("async_rst", M_CLEAR, 5'd0);
        halted = 1'b1;
        return;
      end
      case (smode)
        1:       bus.Stop = (i >= 3);
        2:       bus.Stop = ($urandom_range(0, 5) == 0);
        default: bus.Stop = 1'b0;
      endcase
      s_last = bus.Stop;
      @(posedge Clock);
      #1;
    end
    bus.Stop = 1'b0;
    if (exp_halt || s_last) begin
      for (int k = 0; k < 3; k++) begin
        chk("halt", 24'd0, 5'd0);
        @(posedge Clock);
        #1;
      end
      halted = 1'b1;
    end
  endtask

  task automatic reset_seq();
    Reset = 1'b1;
    #1;
    mcnt = 8'd0;
    chk("rst_hold", M_CLEAR, 5'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    chk("rst_state", M_CLEAR, 5'd0);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset    = 1'b1;
    bus.IR   = 32'd0;
    bus.Stop = 1'b0;
    mcnt     = 8'd0;
    #1;
    chk("por", M_CLEAR, 5'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    chk("rst_state", M_CLEAR, 5'd0);
    @(posedge Clock);
    #1;

    run_instr(32'h28918000, 0, 4);
    reset_seq();
    run_instr(32'h28918000, 0, -1);
    run_instr(32'h00800004, 0, -1);
    run_instr(32'h10800004, 0, -1);
    run_instr(32'h08800010, 0, -1);
    run_instr(32'h58900007, 0, -1);
    run_instr(32'hF8000000, 0, -1);
    run_instr(32'h70918000, 0, -1);
    run_instr(32'h78918000, 0, -1);
    run_instr(32'hD0000000, 0, -1);
    run_instr(32'h28918000, 1, -1);
    reset_seq();
    run_instr(32'hD8000000, 0, -1);
    reset_seq();

    for (int n = 0; n < 256; n++)
      run_instr(32'hD0000000, 0, -1);
    run_instr(32'hD0000000, 0, -1);

    for (int n = 0; n < 80; n++) begin
      run_instr($urandom, 2, -1);
      if (halted) reset_seq();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_control_unit.md
Name: datapath_control_unit

Overview:
- Hardwired Moore control unit that sequences the existing single-bus Datapath.
- Fetches each instruction (T0–T2), decodes IR[31:27], and steps through execute states T3–T7, asserting the same bus-driver, register-enable and ALU-select strobes the bench currently drives by hand.
- Register selection uses Gra/Grb/Grc plus Rin/Rout, decoded by the select-and-encode logic.
- Counts retired instructions.

Parameters:
- OP_W, 5, opcode width (IR[31:27]).
- CNT_W, 16, width of instr_count.
- ADD_OP, 5'b00011, ALU code used for address/immediate adds.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- IR  input  32  current instruction register contents.
- Stop  input  1  level; halt at the next instruction boundary.
- Run  output  1  high while executing.
- Clear  output  1  register-file/PC clear pulse.
- PCout, Zlowout, Zhighout, MDRout, BAout, Cout  output  1 each  bus-driver enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  output  1 each  register load enables.
- IncPC, Read, Write  output  1 each  PC increment, memory read, memory write.
- Gra, Grb, Grc, Rin, Rout  output  1 each  register-field select and in/out.
- alu_op  output  OP_W  ALU operation select.
- instr_count  output  CNT_W  retired-instruction counter.

Behaviour:
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT. The state register advances on the rising edge of Clock.
- All strobes are combinational functions of state and IR[31:27] only. No strobe may depend on another input.
- Reset (asynchronous, any time, including mid-instruction):
  - state=RST, instr_count=0.
  - All strobes 0, alu_op=0, Run=0, Clear=1.
- Next cycle after Reset deasserts: RST->T0.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
  - instr_count increments on the T2->T3 edge and wraps from all-ones to 0.
- Opcodes:
  - ld=00000, ldi=00001, st=00010.
  - R-ALU=00011..01010.
  - I-ALU=01011..01101.
  - mul=01110, div=01111 (feature-gated).
  - nop=11010, halt=11011.
  - Any other opcode executes as nop.
- R-ALU: T3 Grb Rout Yin; T4 Grc Rout Zin, alu_op=IR[31:27]; T5 Zlowout Gra Rin; ->T0.
- I-ALU: T3 Grb Rout Yin; T4 Cout Zin, alu_op=IR[31:27]; T5 Zlowout Gra Rin; ->T0.
- ldi: T3 Grb BAout Yin; T4 Cout Zin, alu_op=ADD_OP; T5 Zlowout Gra Rin; ->T0.
- ld: T3–T4 as ldi; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin; ->T0.
- st: T3–T5 as ld; T6 Gra Rout MDRin (Read=0, so MDR loads from the bus); T7 Write; ->T0.
- nop: T3 asserts nothing; ->T0.
- halt: T3->HALT.
- HALT: all strobes 0, Run=0. Leaves only via Reset.
- Stop: sampled only in the last execute state of an instruction. If high, go to HALT instead of T0. Stop is ignored during fetch.
- alu_op is 0 in every state except T4.
- Run=1 in T0–T7, 0 in RST and HALT.

Optional Feature:
- Macro: CU_MULDIV_EN.
- When defined, mul/div execute as:
  - T3 Gra Rout Yin.
  - T4 Grb Rout Zin, alu_op=IR[31:27].
  - T5 Zlowout LOin.
  - T6 Zhighout HIin.
  - ->T0.
- When undefined, 01110/01111 execute as nop, and HIin, LOin and Zhighout are tied to 0.

Test Plan:
- Reset mid-T4, then release -> Clear=1 and all strobes 0 while Reset is high; RST then T0; instr_count=0.
- IR=0x28918000 (and, op 00101) -> T0..T5 strobes exactly as listed; alu_op=00101 only in T4; back to T0 after 6 cycles; instr_count=1.
- ld opcode 00000 -> Read+MDRin in T6, MDRout+Gra+Rin in T7, 8 cycles total. st opcode 00010 -> Write=1 only in T7.
- Stop=1 raised during T3 of an R-ALU instruction -> T5 completes (Zlowout Gra Rin), then HALT, Run=0; no further T0 until Reset.
- IR opcode 11111 (undefined) -> T3 with no strobes, then T0; instr_count+1. Preload instr_count to 0xFFFF via 65535 nops -> next T2->T3 edge wraps to 0x0000.
- With CU_MULDIV_EN, opcode 01110 -> LOin in T5, HIin+Zhighout in T6. Without it -> nop timing; HIin and LOin never asserted.
